if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined ARM core, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to a variable-latency instruction memory, with one request outstanding.
- Presents instrF, PCF and PCPlus4F with a validF qualifier to the IF/ID register.
- Accepts a stall from hazard control and a taken-branch redirect from execute.

---
 rtl/if_fetch_stage.sv | 103 ++++++++++
 tb/tb_if_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID presentation
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding, requesting pc
    S_WAIT = 2'd1,  // request accepted, data will be kept
    S_HOLD = 2'd2,  // instruction presented to IF/ID
    S_DROP = 2'd3   // request accepted, data will be thrown away
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pcf_q;
  logic [31:0] pcp4_q;
  logic        valid_q;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic        accepted;

  // pc+4 wraps naturally in 32 bits; redirect target is forced word-aligned
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = branchAddr & 32'hFFFF_FFFC;

  // Request only when nothing is in flight: idle, or the held instruction leaves this cycle.
  // A redirect cycle never requests, so the old pc can never be fetched.
  assign imem_req  = !branchTaken &&
                     ((state_q == S_IDLE) || ((state_q == S_HOLD) && !stallF));
  assign imem_addr = (state_q == S_HOLD) ? pc_plus4 : pc_q;
  assign accepted  = imem_req && imem_ready;

  assign instrF   = instr_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcp4_q;
  assign validF   = valid_q;

  // Fetch FSM with pc and IF/ID output registers; redirect outranks stall and rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcf_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (branchTaken) begin
      pc_q    <= branch_tgt;
      valid_q <= 1'b0;
      if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid) begin
        state_q <= S_DROP;
      end else begin
        state_q <= S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accepted) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            pcf_q   <= pc_q;
            pcp4_q  <= pc_plus4;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stallF) begin
            pc_q    <= pc_plus4;
            valid_q <= 1'b0;
            state_q <= accepted ? S_WAIT : S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage with memory and fetch-stream model
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallF = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  int checks = 0;
  int failures = 0;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .branchTaken(branchTaken), .branchAddr(branchAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // instruction memory contents: address 0 holds E3A00001
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hE3A0_0001;
  endfunction

  // memory model: one pending read, delivered mem_cnt cycles after the acceptance cycle + 1
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  int          lat = 0;
  logic        rand_lat = 1'b0;

  // fetch-stream reference model
  logic [31:0] m_pc = RST_PC;    // next address to fetch
  logic        m_inflight = 1'b0; // a fetch is out whose data will be presented
  logic        m_discard = 1'b0;  // a fetch is out whose data was cancelled by a redirect
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pcf = 32'd0;
  logic [31:0] m_pcp4 = 32'd0;

  task automatic model_reset();
    m_pc = RST_PC; m_inflight = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
    m_instr = 32'd0; m_pcf = 32'd0; m_pcp4 = 32'd0;
    mem_pend = 1'b0; mem_cnt = 0;
  endtask

  task automatic step(input logic st, input logic bt, input logic [31:0] ba,
                      input logic rdy, input logic spur);
    logic        e_req;
    logic [31:0] e_addr;
    logic        acc, rv, delivered;
    logic [31:0] rd;
    @(negedge clk);
    stallF = st; branchTaken = bt; branchAddr = ba; imem_ready = rdy;
    delivered = mem_pend && (mem_cnt == 0);
    if (delivered) begin
      imem_rvalid = 1'b1; imem_rdata = memf(mem_addr);
    end else begin
      imem_rvalid = spur && !mem_pend; imem_rdata = $urandom;
    end
    rv = imem_rvalid; rd = imem_rdata;
    // a fetch is issued when nothing is out and nothing is held, or the held one leaves now
    e_req  = !bt && ((!m_inflight && !m_discard && !m_valid) || (m_valid && !st));
    e_addr = m_valid ? m_pc + 32'd4 : m_pc;
    acc    = e_req && rdy;
    #1;
    check_val("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check_val("imem_addr", imem_addr, e_addr);
    check_val("validF", {31'd0, validF}, {31'd0, m_valid});
    check_val("instrF", instrF, m_instr);
    check_val("PCF", PCF, m_pcf);
    check_val("PCPlus4F", PCPlus4F, m_pcp4);
    @(posedge clk);
    if (bt) begin
      m_pc = ba & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_discard = (m_inflight || m_discard) && !rv;
      m_inflight = 1'b0;
    end else if (m_inflight && rv) begin
      m_instr = rd; m_pcf = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_inflight = 1'b0;
    end else if (m_discard && rv) begin
      m_discard = 1'b0;
    end else if (m_valid && !st) begin
      m_pc = m_pc + 32'd4; m_valid = 1'b0; m_inflight = acc;
    end else if (!m_inflight && !m_discard && !m_valid) begin
      m_inflight = acc;
    end
    if (delivered) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (acc) begin
      mem_pend = 1'b1; mem_addr = e_addr;
      mem_cnt = rand_lat ? int'($urandom_range(0, 3)) : lat;
    end
  endtask

  // asynchronous reset pulse between clock edges, outputs must clear with no edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    stallF = 1'b0; branchTaken = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rst_validF", {31'd0, validF}, 32'd0);
    check_val("rst_instrF", instrF, 32'd0);
    check_val("rst_PCF", PCF, 32'd0);
    check_val("rst_PCPlus4F", PCPlus4F, 32'd0);
    check_val("rst_addr", imem_addr, RST_PC);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // first fetch from reset pc with 1-cycle memory
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    #1;
    check_val("first_valid", {31'd0, validF}, 32'd1);
    check_val("first_instr", instrF, 32'hE3A0_0001);
    check_val("first_pcf", PCF, 32'd0);
    check_val("first_pcp4", PCPlus4F, 32'd4);
    step(0, 0, 0, 1, 0);  // consume, request 4
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);  // consume, request 8
    step(0, 0, 0, 1, 0);
    // stall three cycles while PCF=8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 0);
      #1;
      check_val("stall_pcf", PCF, 32'd8);
      check_val("stall_valid", {31'd0, validF}, 32'd1);
      check_val("stall_instr", instrF, memf(32'd8));
    end
    step(0, 0, 0, 1, 0);  // release, request 12
    step(0, 0, 0, 1, 0);
    lat = 1;
    step(0, 0, 0, 1, 0);  // consume 12, request 16 -> WAIT, data two cycles later
    step(0, 1, 32'h0000_0103, 1, 0);  // redirect while waiting
    step(0, 0, 0, 0, 0);  // stale data arrives and is dropped
    #1;
    check_val("drop_valid", {31'd0, validF}, 32'd0);
    lat = 0;
    step(0, 0, 0, 1, 0);  // request 0x100
    step(0, 1, 32'h0000_0200, 1, 0);  // redirect in the same cycle as rvalid
    #1;
    check_val("br_rv_valid", {31'd0, validF}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);  // memory not ready
    step(0, 0, 0, 1, 0);  // accepted at 0x200
    step(0, 0, 0, 1, 0);
    #1;
    check_val("after_br_pcf", PCF, 32'h0000_0200);
    // wrap at top of address space
    step(0, 1, 32'hFFFF_FFFF, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    #1;
    check_val("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check_val("wrap_pcp4", PCPlus4F, 32'd0);
    lat = 2;
    step(0, 0, 0, 1, 0);  // consume, request 0 -> WAIT
    do_reset();
    step(0, 0, 0, 0, 1);  // late response after reset must be ignored
    #1;
    check_val("late_rv_valid", {31'd0, validF}, 32'd0);
    // randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, ba,
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
